// File: rtl/wb_unit_if.sv
// Writeback-stage bus: mem_wb entry handshake, RAM response, and regfile write port.
// in_valid_i/in_ready_o: an entry transfers on a cycle where both are high; in_ready_o never depends on in_valid_i.
interface wb_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [REG_AW-1:0] rd_addr_i;
  logic [XLEN-1:0]   rd_data_i;
  logic              rd_wen_i;
  logic              mem_re_i;
  logic [1:0]        mem_size_i;
  logic              mem_unsigned_i;
  logic [OFF_W-1:0]  mem_off_i;
  logic              ram_rsp_valid_i;
  logic [XLEN-1:0]   ram_rdata_i;
  logic              rd_wen_o;
  logic [REG_AW-1:0] rd_addr_o;
  logic [XLEN-1:0]   rd_data_o;
  logic [XLEN-1:0]   retired_o;
  logic              timeout_o;
  logic              state_dbg;

  modport master (
    output in_valid_i, rd_addr_i, rd_data_i, rd_wen_i, mem_re_i, mem_size_i,
           mem_unsigned_i, mem_off_i, ram_rsp_valid_i, ram_rdata_i,
    input  in_ready_o, rd_wen_o, rd_addr_o, rd_data_o, retired_o, timeout_o, state_dbg
  );

  modport slave (
    input  in_valid_i, rd_addr_i, rd_data_i, rd_wen_i, mem_re_i, mem_size_i,
           mem_unsigned_i, mem_off_i, ram_rsp_valid_i, ram_rdata_i,
    output in_ready_o, rd_wen_o, rd_addr_o, rd_data_o, retired_o, timeout_o, state_dbg
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: merges ALU results and load responses, formats load data, counts retirements.
// Optional load watchdog enabled by defining WB_TIMEOUT_EN.
module wb_unit #(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int OFF_W          = $clog2(XLEN/8),
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic       clk,
  input logic       rst,
  wb_unit_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              in_wait, accept, alu_commit, load_commit, tmo_fire, commit;
  logic [REG_AW-1:0] cap_addr, sel_addr;
  logic              cap_wen, sel_wen, cap_uns, sel_uns;
  logic [1:0]        cap_size, sel_size;
  logic [OFF_W-1:0]  cap_off, sel_off, h_idx, w_idx;
  logic [XLEN-1:0]   sh_b, sh_h, sh_w, mask, fmt, wr_data;
  logic              sign_bit;
  logic              wen_q;
  logic [REG_AW-1:0] addr_q;
  logic [XLEN-1:0]   data_q, retired_q;

  assign in_wait = (state == WAIT_RSP);
  assign accept  = bus.in_valid_i && bus.in_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && bus.mem_re_i && !bus.ram_rsp_valid_i) state_nxt = WAIT_RSP;
      WAIT_RSP: if (bus.ram_rsp_valid_i || tmo_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o = (state == IDLE);
    bus.state_dbg  = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= '0;
      cap_wen  <= 1'b0;
      cap_uns  <= 1'b0;
      cap_size <= 2'd0;
      cap_off  <= '0;
    end else if (accept && bus.mem_re_i) begin
      cap_addr <= bus.rd_addr_i;
      cap_wen  <= bus.rd_wen_i;
      cap_uns  <= bus.mem_unsigned_i;
      cap_size <= bus.mem_size_i;
      cap_off  <= bus.mem_off_i;
    end
  end

  // A zero-wait load formats from the live inputs; a stalled one from the captured fields.
  assign sel_addr = in_wait ? cap_addr : bus.rd_addr_i;
  assign sel_wen  = in_wait ? cap_wen  : bus.rd_wen_i;
  assign sel_uns  = in_wait ? cap_uns  : bus.mem_unsigned_i;
  assign sel_size = in_wait ? cap_size : bus.mem_size_i;
  assign sel_off  = in_wait ? cap_off  : bus.mem_off_i;

  assign h_idx = sel_off >> 1;
  assign w_idx = sel_off >> 2;
  assign sh_b  = bus.ram_rdata_i >> {sel_off, 3'b000};
  assign sh_h  = bus.ram_rdata_i >> {h_idx, 4'b0000};
  assign sh_w  = bus.ram_rdata_i >> {w_idx, 5'b00000};

  // On XLEN=32 the word mask is all ones, so W and D keep the raw word unextended.
  always_comb begin
    fmt      = '0;
    mask     = '1;
    sign_bit = 1'b0;
    case (sel_size)
      2'd0: begin fmt = sh_b; mask = XLEN'(8'hFF);         sign_bit = sh_b[7];  end
      2'd1: begin fmt = sh_h; mask = XLEN'(16'hFFFF);      sign_bit = sh_h[15]; end
      2'd2: begin fmt = sh_w; mask = XLEN'(32'hFFFF_FFFF); sign_bit = sh_w[31]; end
      default: begin
        if (XLEN == 32) begin
          fmt = sh_w; mask = XLEN'(32'hFFFF_FFFF); sign_bit = sh_w[31];
        end else begin
          fmt = bus.ram_rdata_i; mask = '1; sign_bit = 1'b0;
        end
      end
    endcase
    fmt = fmt & mask;
    if (!sel_uns && sign_bit) fmt = fmt | ~mask;
  end

  assign alu_commit  = accept && !bus.mem_re_i;
  assign load_commit = bus.ram_rsp_valid_i && (in_wait || (accept && bus.mem_re_i));
  assign commit      = alu_commit || load_commit || tmo_fire;
  assign wr_data     = alu_commit ? bus.rd_data_i : (tmo_fire ? '0 : fmt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      wen_q <= 1'b0;
      if (commit) begin
        wen_q     <= (alu_commit ? bus.rd_wen_i : sel_wen) && (sel_addr != '0);
        addr_q    <= sel_addr;
        data_q    <= wr_data;
        retired_q <= retired_q + XLEN'(1);
      end
    end
  end

  assign bus.rd_wen_o  = wen_q;
  assign bus.rd_addr_o = addr_q;
  assign bus.rd_data_o = data_q;
  assign bus.retired_o = retired_q;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  // A response on the limit cycle wins, so the watchdog only fires without one.
  assign tmo_fire = in_wait && !bus.ram_rsp_valid_i && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_wait)                            cnt <= '0;
      else if (!bus.ram_rsp_valid_i)           cnt <= cnt + 1'b1;
      if (tmo_fire)                            timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign tmo_fire = 1'b0;
  // Constant 0 for any legal limit; the watchdog is compiled out.
  assign bus.timeout_o = (TIMEOUT_CYCLES < 1);
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: ALU writes, x0 rule, load formatting, stalls, reset, watchdog.
module tb_wb_unit;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  wb_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  wb_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.in_valid_i      = 1'b0;
    bus.rd_addr_i       = '0;
    bus.rd_data_i       = '0;
    bus.rd_wen_i        = 1'b0;
    bus.mem_re_i        = 1'b0;
    bus.mem_size_i      = 2'd0;
    bus.mem_unsigned_i  = 1'b0;
    bus.mem_off_i       = '0;
    bus.ram_rsp_valid_i = 1'b0;
    bus.ram_rdata_i     = '0;
  endtask

  task automatic drive_alu(input logic [4:0] addr, input logic [31:0] data, input logic wen);
    bus.in_valid_i = 1'b1;
    bus.rd_addr_i  = addr;
    bus.rd_data_i  = data;
    bus.rd_wen_i   = wen;
    bus.mem_re_i   = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] addr, input logic [1:0] size, input logic uns,
                            input logic [1:0] off, input logic rsp, input logic [31:0] rdata);
    bus.in_valid_i      = 1'b1;
    bus.rd_addr_i       = addr;
    bus.rd_data_i       = 32'h5555_5555;
    bus.rd_wen_i        = 1'b1;
    bus.mem_re_i        = 1'b1;
    bus.mem_size_i      = size;
    bus.mem_unsigned_i  = uns;
    bus.mem_off_i       = off;
    bus.ram_rsp_valid_i = rsp;
    bus.ram_rdata_i     = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    #12;
    check("rst_wen", bus.rd_wen_o, 0);
    check("rst_addr", bus.rd_addr_o, 0);
    check("rst_data", bus.rd_data_o, 0);
    check("rst_retired", bus.retired_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    check("rst_ready", bus.in_ready_o, 1);
    rst = 1'b0;
    step();

    // ALU op to x5
    drive_alu(5'd5, 32'h1234, 1'b1);
    step();
    check("alu_wen", bus.rd_wen_o, 1);
    check("alu_addr", bus.rd_addr_o, 5);
    check("alu_data", bus.rd_data_o, 32'h1234);
    check("alu_retired", bus.retired_o, 1);
    drive_idle();
    step();
    check("alu_pulse", bus.rd_wen_o, 0);
    check("alu_hold_addr", bus.rd_addr_o, 5);
    check("alu_hold_data", bus.rd_data_o, 32'h1234);

    // ALU with rd_wen=0 still retires
    drive_alu(5'd6, 32'hBEEF, 1'b0);
    step();
    check("nowen_wen", bus.rd_wen_o, 0);
    check("nowen_retired", bus.retired_o, 2);

    // x0 write
    drive_alu(5'd0, 32'hDEAD, 1'b1);
    step();
    check("x0_wen", bus.rd_wen_o, 0);
    check("x0_retired", bus.retired_o, 3);

    // LB signed, zero-wait
    drive_load(5'd7, 2'd0, 1'b0, 2'd2, 1'b1, 32'h0080_0000);
    step();
    check("lb_wen", bus.rd_wen_o, 1);
    check("lb_addr", bus.rd_addr_o, 7);
    check("lb_data", bus.rd_data_o, 32'hFFFF_FF80);
    check("lb_ready", bus.in_ready_o, 1);
    check("lb_retired", bus.retired_o, 4);

    // LBU, zero-wait
    drive_load(5'd8, 2'd0, 1'b1, 2'd2, 1'b1, 32'h0080_0000);
    step();
    check("lbu_data", bus.rd_data_o, 32'h0000_0080);
    check("lbu_retired", bus.retired_o, 5);

    // LHU at offset 3: o[0] ignored, upper half selected
    drive_load(5'd10, 2'd1, 1'b1, 2'd3, 1'b1, 32'hABCD_0000);
    step();
    check("lhu_data", bus.rd_data_o, 32'h0000_ABCD);

    // LW signed is the raw word on XLEN=32
    drive_load(5'd11, 2'd2, 1'b0, 2'd3, 1'b1, 32'h8765_4321);
    step();
    check("lw_data", bus.rd_data_o, 32'h8765_4321);

    // Stray response in IDLE is ignored
    drive_idle();
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_rdata_i     = 32'hFFFF_FFFF;
    step();
    check("stray_wen", bus.rd_wen_o, 0);
    check("stray_retired", bus.retired_o, 7);

    // LH with 3-cycle RAM latency; live inputs changed during the stall
    drive_load(5'd9, 2'd1, 1'b0, 2'd2, 1'b0, 32'h0);
    step();
    drive_idle();
    bus.rd_addr_i = 5'd3;
    bus.mem_unsigned_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("lh_stall_ready", bus.in_ready_o, 0);
      check("lh_stall_wen", bus.rd_wen_o, 0);
      if (i < 2) step();
    end
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_rdata_i     = 32'h8001_0000;
    step();
    check("lh_wen", bus.rd_wen_o, 1);
    check("lh_addr", bus.rd_addr_o, 9);
    check("lh_data", bus.rd_data_o, 32'hFFFF_8001);
    check("lh_ready", bus.in_ready_o, 1);
    check("lh_retired", bus.retired_o, 8);
    drive_idle();
    step();
    check("lh_pulse", bus.rd_wen_o, 0);

    // Reset while waiting drops the load
    drive_load(5'd12, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
    step();
    drive_idle();
    check("rstw_ready_before", bus.in_ready_o, 0);
    rst = 1'b1;
    #2;
    check("rstw_state", bus.state_dbg, 0);
    check("rstw_retired", bus.retired_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_rdata_i     = 32'h1111_1111;
    step();
    check("rstw_wen", bus.rd_wen_o, 0);
    check("rstw_ready", bus.in_ready_o, 1);
    check("rstw_retired_after", bus.retired_o, 0);
    drive_idle();
    step();

`ifdef WB_TIMEOUT_EN
    // Watchdog with limit 4: write of 0 four cycles after entering WAIT_RSP
    drive_load(5'd13, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
    step();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_wait_wen", bus.rd_wen_o, 0);
      check("tmo_wait_flag", bus.timeout_o, 0);
      check("tmo_wait_ready", bus.in_ready_o, 0);
    end
    step();
    check("tmo_wen", bus.rd_wen_o, 1);
    check("tmo_addr", bus.rd_addr_o, 13);
    check("tmo_data", bus.rd_data_o, 0);
    check("tmo_flag", bus.timeout_o, 1);
    check("tmo_ready", bus.in_ready_o, 1);
    check("tmo_retired", bus.retired_o, 1);
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_rdata_i     = 32'h2222_2222;
    step();
    check("tmo_late_wen", bus.rd_wen_o, 0);
    check("tmo_sticky", bus.timeout_o, 1);
    check("tmo_late_retired", bus.retired_o, 1);
    drive_idle();
`else
    // Without the watchdog a load waits indefinitely
    drive_load(5'd13, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
    step();
    drive_idle();
    repeat (8) step();
    check("notmo_ready", bus.in_ready_o, 0);
    check("notmo_wen", bus.rd_wen_o, 0);
    check("notmo_flag", bus.timeout_o, 0);
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_rdata_i     = 32'h0000_0042;
    step();
    check("notmo_data", bus.rd_data_o, 32'h42);
    check("notmo_addr", bus.rd_addr_o, 13);
    drive_idle();
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Parametrised writeback stage for the pipelined RV core. Sits between the mem_wb pipeline register and the register file.
- Merges ALU results and data-RAM load responses, and handles variable-latency loads with a stall handshake.
- Aligns and sign/zero-extends load data, registers the regfile write port, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- OFF_W, $clog2(XLEN/8), byte-offset width; derived, do not override.
- TIMEOUT_CYCLES, 256, load-response watchdog limit; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  mem_wb entry valid.
- in_ready_o  out  1  wb can accept an entry.
- rd_addr_i  in  REG_AW  destination register.
- rd_data_i  in  XLEN  ALU/CSR result.
- rd_wen_i  in  1  instruction writes rd.
- mem_re_i  in  1  instruction is a load.
- mem_size_i  in  2  load size: 0=B, 1=H, 2=W, 3=D.
- mem_unsigned_i  in  1  zero-extend (LBU/LHU/LWU).
- mem_off_i  in  OFF_W  low address bits of the load.
- ram_rsp_valid_i  in  1  RAM read data valid.
- ram_rdata_i  in  XLEN  RAM read data, full aligned word.
- rd_wen_o  out  1  regfile write strobe.
- rd_addr_o  out  REG_AW  regfile write address.
- rd_data_o  out  XLEN  regfile write data.
- retired_o  out  XLEN  retired-instruction count.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state=IDLE; rd_wen_o=0, rd_addr_o=0, rd_data_o=0, retired_o=0, timeout_o=0. Reset mid-load drops the pending load; no write is issued.
- States:
  - IDLE: in_ready_o=1.
  - WAIT_RSP: in_ready_o=0, which stalls the pipeline.
- Accept: an entry is accepted when in_valid_i && in_ready_o.
- Non-load accept (mem_re_i=0): next cycle rd_wen_o=rd_wen_i && (rd_addr_i!=0), rd_addr_o=rd_addr_i, rd_data_o=rd_data_i. State stays IDLE.
- Load accept: capture rd_addr, rd_wen, size, unsigned and offset.
  - If ram_rsp_valid_i is high the same cycle, write formatted data next cycle and stay IDLE (zero-wait RAM).
  - Otherwise go to WAIT_RSP.
- WAIT_RSP: on ram_rsp_valid_i, write formatted data next cycle using the captured fields, then return to IDLE. A load with rd_wen=0 still waits for its response, which is then discarded.
- ram_rsp_valid_i in IDLE with no load being accepted is ignored.
- Write latency: exactly 1 cycle from accept (non-load) or from response (load). rd_wen_o is a single-cycle pulse; otherwise it is 0. rd_addr_o and rd_data_o hold their last value.
- x0 rule: a write to x0 never asserts rd_wen_o, but still counts as retired.
- Load formatting (o = captured offset):
  - B: byte ram_rdata_i[8*o +: 8].
  - H: half at bit 16*o[OFF_W-1:1]; o[0] ignored.
  - W: word at bit 32*o[OFF_W-1:2] (XLEN=64), else the whole word; low offset bits ignored.
  - D: whole word. For XLEN=32, D is treated as W.
  - Extension: sign-extend to XLEN unless mem_unsigned_i. For W with XLEN=32, extension is a no-op.
- retired_o increments by 1 in the same cycle rd_wen_o would be evaluated, i.e. one per committed instruction regardless of rd_wen. It wraps modulo 2^XLEN.
- Stall: in_ready_o is combinational from state only, with no dependence on in_valid_i.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RSP and increments each cycle without a response.
  - When it reaches TIMEOUT_CYCLES-1 with no response: issue the write next cycle with rd_data_o=0 (rd_wen_o gated as usual), set timeout_o=1 (sticky until rst), and return to IDLE.
  - A response arriving in the same cycle as the limit wins over the timeout.
  - A late response after a timeout is ignored.
- Not defined: WAIT_RSP waits indefinitely, the counter is absent, and timeout_o is tied to 0.

Test Plan:
- ALU op: rd_addr=5, rd_data=0x1234, wen=1, mem_re=0 → next cycle rd_wen_o=1, addr 5, data 0x1234; retired_o=1.
- x0 write: rd_addr=0, wen=1 → rd_wen_o stays 0; retired_o increments.
- LB signed, zero-wait: off=2, rdata=0x00800000, response same cycle → next cycle data 0xFFFFFF80. Same with LBU → 0x00000080.
- LH with 3-cycle RAM latency: off=2, rdata=0x8001_0000 → in_ready_o=0 for 3 cycles, write 0xFFFF8001 one cycle after response, then in_ready_o=1.
- rst asserted while in WAIT_RSP, then released, then a response arrives → no write, state IDLE, retired_o=0.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response → write of 0 after the limit, timeout_o=1. A late ram_rsp_valid_i is ignored.
